rr_mux4_arbiter: RTL and testbench
==================================

Name: rr_mux4_arbiter

Overview:
- Upstream feeder for the 4:1 lane mux in the ALU multi-mux path.
- Four requesters each present a WIDTH-bit lane with valid/ready. A round-robin arbiter picks one lane per cycle and produces the 2-bit select.
- The selected lane is registered into a single output slot with a valid/ready handshake to the consumer.
- The packed lane input is laid out exactly as the mux expects: lane k occupies in_data[k*WIDTH +: WIDTH].

Parameters:
- WIDTH, 3, bits per lane; in_data is 4*WIDTH wide.
- RESET_LAST, 3, initial last-grant index, so lane (RESET_LAST+1)%4 has first priority after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  4  per-lane request.
- in_data  input  4*WIDTH  packed lanes, lane k at [k*WIDTH +: WIDTH].
- in_ready  output  4  one-hot or zero; lane k transfers on a cycle where in_valid[k] & in_ready[k].
- out_valid  output  1  output slot holds data.
- out_data  output  WIDTH  registered selected lane.
- out_sel  output  2  registered index of the lane in out_data; drives the mux select.
- out_ready  input  1  consumer accepts when out_valid & out_ready.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - out_valid=0, out_data=0, out_sel=0, last_grant=RESET_LAST.
  - in_ready=0 while rst_n=0.
- State: EMPTY (out_valid=0) / FULL (out_valid=1).
- Internal pipe_ready = !out_valid | out_ready.
- Arbitration (combinational):
  - Scan lanes last_grant+1, +2, +3, +4 (mod 4).
  - The first lane with in_valid set is the grant.
  - No valid lane gives no grant.
- in_ready[k] = grant[k] & pipe_ready. At most one bit is set. Never depends on in_valid of other lanes beyond the priority scan.
- On clock edge with a grant and pipe_ready:
  - out_data <= lane data.
  - out_sel <= grant index.
  - last_grant <= grant index.
  - out_valid <= 1.
- Latency: 1 cycle from accepted input to out_valid.
- Throughput: 1 transfer per cycle when out_ready is held high.
- Transitions:
  - EMPTY to FULL on grant.
  - FULL to FULL on out_ready & grant (simultaneous drain and load; new data replaces old in the same edge).
  - FULL to EMPTY on out_ready & no grant.
  - FULL hold on !out_ready: out_data/out_sel stable, in_ready=0, last_grant unchanged.
- Fairness:
  - A lane continuously valid is granted within 4 accepted transfers.
  - A lone valid lane is granted every cycle (no forced idle).
- Wrap-around: last_grant=3 means lane 0 is checked first.
- Reset mid-operation: the slot is dropped immediately (out_valid=0) and priority returns to RESET_LAST+1. The upstream must re-present.
- The consumer must not see out_data/out_sel change while out_valid & !out_ready.

Optional Feature:
- Macro: RR_MUX4_GRANT_COUNT_EN.
- With the macro defined:
  - Adds output grant_count of width 32: four 8-bit saturating counters, lane k at [k*8 +: 8].
  - Each counter increments on every accepted transfer from its lane and saturates at 255.
  - Counters clear on reset and on input clr_counts (1-bit, synchronous). If clr_counts coincides with a transfer, the clear wins.
- Without the macro: neither port exists and no counter logic is synthesised. Core behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 with in_valid=4'b1111.
  - Required: out_valid=0, out_sel=0, in_ready=0.
  - Release reset with out_ready=1: first grant is lane 0.
- Round robin: in_valid=4'b1111, in_data lanes = 3'd1, 3'd2, 3'd3, 3'd4, out_ready=1.
  - Required out_sel sequence over 5 cycles: 0,1,2,3,0.
  - out_data matches 1,2,3,4,1, each one cycle after its in_ready.
- Backpressure: fill slot with lane 2 (data 3'd5), then out_ready=0 for 3 cycles with in_valid=4'b1011.
  - Required: out_data=5, out_sel=2 held; in_ready=0.
  - Raise out_ready: next grant is lane 3.
- Sparse/wrap: only lane 1 valid for 3 cycles, then only lane 0.
  - Required: lane 1 granted every cycle, then lane 0 with out_sel=0.
  - No bubble beyond the 1-cycle latency.
- Drain-to-empty: slot FULL, out_ready=1, in_valid=0.
  - Required: out_valid falls the next cycle and out_sel retains its last value.
- Async reset mid-stream: pull rst_n low between clock edges while FULL.
  - Required: out_valid=0 immediately, without waiting for a clock edge.
  - With RR_MUX4_GRANT_COUNT_EN: 300 lane-0 transfers give lane-0 count 255; clr_counts gives 0.

Source files
------------

// File: rtl/rr_mux4_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux4_arbiter_if
// Description : Lane-request and output-slot handshake bundle for the 4:1
//               round-robin lane arbiter. Lane k sits at
//               in_data[k*WIDTH +: WIDTH].
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_mux4_arbiter_if #(
  parameter int WIDTH = 3
);
  logic [3:0]         in_valid;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_sel;
  logic               out_ready;

  // Arbiter side: consumes lane requests, owns the output slot.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sel,
    input  out_ready
  );

  // Environment side: presents lanes and consumes the output slot.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sel,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/rr_mux4_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux4_arbiter
// Description : Four-lane round-robin arbiter feeding a single registered
//               output slot (data + 2-bit mux select) with valid/ready.
//               Optional per-lane saturating grant counters are enabled by
//               defining RR_MUX4_GRANT_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux4_arbiter #(
  parameter int WIDTH      = 3,
  parameter int RESET_LAST = 3
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  rr_mux4_arbiter_if.slave   bus
`ifdef RR_MUX4_GRANT_COUNT_EN
  ,
  input  wire logic          clr_counts,
  output logic [31:0]        grant_count
`endif
);

  localparam logic [1:0] RESET_LAST_IDX = 2'(RESET_LAST);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_sel_q, out_sel_d;
  logic [1:0]       last_grant_q, last_grant_d;

  logic             grant_vld;
  logic [1:0]       grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             pipe_ready;
  logic             xfer;
  logic [3:0]       in_ready_w;

  // Priority scan starting one past the last granted lane, wrapping mod 4.
  always_comb begin
    logic [1:0] scan_idx;
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    scan_idx  = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      scan_idx = last_grant_q + 2'(i);
      if (!grant_vld && bus.in_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // Select the granted lane's data with constant slices only.
  always_comb begin
    grant_data = '0;
    for (int k = 0; k < 4; k++) begin
      if (grant_idx == 2'(k)) begin
        grant_data = bus.in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Slot can accept when empty or being drained this cycle; ready is held low during reset.
  always_comb begin
    pipe_ready = (state_q == ST_EMPTY) || bus.out_ready;
    xfer       = grant_vld && pipe_ready && rst_n;
    in_ready_w = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      if (xfer && (grant_idx == 2'(k))) begin
        in_ready_w[k] = 1'b1;
      end
    end
  end

  // Next-state and slot contents: load on transfer, drop to empty on a drain with no grant.
  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    last_grant_d = last_grant_q;
    if (xfer) begin
      out_data_d   = grant_data;
      out_sel_d    = grant_idx;
      last_grant_d = grant_idx;
    end
    case (state_q)
      ST_EMPTY: begin
        if (xfer) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (bus.out_ready && !xfer) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State register; reset drops the slot immediately and restores initial priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      out_data_q   <= '0;
      out_sel_q    <= 2'd0;
      last_grant_q <= RESET_LAST_IDX;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

`ifdef RR_MUX4_GRANT_COUNT_EN
  for (genvar k = 0; k < 4; k++) begin : g_cnt
    logic [7:0] cnt_q, cnt_d;

    // Saturating per-lane transfer count; a clear overrides a coincident transfer.
    always_comb begin
      cnt_d = cnt_q;
      if (clr_counts) begin
        cnt_d = 8'd0;
      end else if (in_ready_w[k] && bus.in_valid[k] && (cnt_q != 8'hFF)) begin
        cnt_d = cnt_q + 8'd1;
      end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= 8'd0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign grant_count[k*8 +: 8] = cnt_q;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_mux4_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_mux4_arbiter
// Description : Directed self-checking bench for rr_mux4_arbiter. Counter
//               checks are included when RR_MUX4_GRANT_COUNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_mux4_arbiter;

  localparam int WIDTH = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  rr_mux4_arbiter_if #(.WIDTH(WIDTH)) bus ();

`ifdef RR_MUX4_GRANT_COUNT_EN
  logic        clr_counts;
  logic [31:0] grant_count;
`endif

  rr_mux4_arbiter #(.WIDTH(WIDTH), .RESET_LAST(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus)
`ifdef RR_MUX4_GRANT_COUNT_EN
    ,
    .clr_counts (clr_counts),
    .grant_count(grant_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Lanes 0..3 carry data 1, 2, 5, 4.
  task automatic apply_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 4'b0000;
    bus.in_data   = {3'd4, 3'd5, 3'd2, 3'd1};
    bus.out_ready = 1'b1;
`ifdef RR_MUX4_GRANT_COUNT_EN
    clr_counts    = 1'b0;
`endif
    repeat (2) step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 4'b1111;
    bus.in_data   = {3'd4, 3'd3, 3'd2, 3'd1};
    bus.out_ready = 1'b1;
`ifdef RR_MUX4_GRANT_COUNT_EN
    clr_counts    = 1'b0;
`endif
    repeat (3) step();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", bus.out_valid); end
    checks++; if (bus.out_sel !== 2'd0) begin failures++; $display("FAIL reset_out_sel got=%0h exp=0", bus.out_sel); end
    checks++; if (bus.out_data !== 3'd0) begin failures++; $display("FAIL reset_out_data got=%0h exp=0", bus.out_data); end
    checks++; if (bus.in_ready !== 4'b0000) begin failures++; $display("FAIL reset_in_ready got=%b exp=0000", bus.in_ready); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 4'b0001) begin failures++; $display("FAIL reset_first_grant got=%b exp=0001", bus.in_ready); end
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd0 || bus.out_data !== 3'd1)
      begin failures++; $display("FAIL reset_first_out got v=%0h s=%0h d=%0h exp v=1 s=0 d=1", bus.out_valid, bus.out_sel, bus.out_data); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_sel [5];
    logic [2:0] exp_dat [5];
    exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_dat = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
    apply_reset();
    bus.in_data  = {3'd4, 3'd3, 3'd2, 3'd1};
    bus.in_valid = 4'b1111;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.in_ready !== (4'b0001 << exp_sel[i]))
        begin failures++; $display("FAIL rr_in_ready[%0d] got=%b exp=%b", i, bus.in_ready, 4'b0001 << exp_sel[i]); end
      step();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_sel !== exp_sel[i] || bus.out_data !== exp_dat[i])
        begin failures++; $display("FAIL rr_out[%0d] got v=%0h s=%0h d=%0h exp v=1 s=%0h d=%0h", i, bus.out_valid, bus.out_sel, bus.out_data, exp_sel[i], exp_dat[i]); end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    bus.in_valid = 4'b0100;
    #1;
    checks++; if (bus.in_ready !== 4'b0100) begin failures++; $display("FAIL bp_fill_ready got=%b exp=0100", bus.in_ready); end
    step();
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.in_ready !== 4'b0000) begin failures++; $display("FAIL bp_in_ready[%0d] got=%b exp=0000", i, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd2 || bus.out_data !== 3'd5)
        begin failures++; $display("FAIL bp_hold[%0d] got v=%0h s=%0h d=%0h exp v=1 s=2 d=5", i, bus.out_valid, bus.out_sel, bus.out_data); end
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 4'b1000) begin failures++; $display("FAIL bp_next_grant got=%b exp=1000", bus.in_ready); end
    step();
    checks++; if (bus.out_sel !== 2'd3 || bus.out_data !== 3'd4)
      begin failures++; $display("FAIL bp_next_out got s=%0h d=%0h exp s=3 d=4", bus.out_sel, bus.out_data); end
  endtask

  task automatic test_sparse_wrap();
    apply_reset();
    bus.in_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.in_ready !== 4'b0010) begin failures++; $display("FAIL sparse_ready[%0d] got=%b exp=0010", i, bus.in_ready); end
      step();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd1 || bus.out_data !== 3'd2)
        begin failures++; $display("FAIL sparse_out[%0d] got v=%0h s=%0h d=%0h exp v=1 s=1 d=2", i, bus.out_valid, bus.out_sel, bus.out_data); end
    end
    bus.in_valid = 4'b0001;
    #1;
    checks++; if (bus.in_ready !== 4'b0001) begin failures++; $display("FAIL wrap_ready got=%b exp=0001", bus.in_ready); end
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd0 || bus.out_data !== 3'd1)
      begin failures++; $display("FAIL wrap_out got v=%0h s=%0h d=%0h exp v=1 s=0 d=1", bus.out_valid, bus.out_sel, bus.out_data); end
  endtask

  task automatic test_drain();
    apply_reset();
    bus.in_valid = 4'b0100;
    step();
    bus.in_valid = 4'b0000;
    #1;
    checks++; if (bus.in_ready !== 4'b0000) begin failures++; $display("FAIL drain_ready got=%b exp=0000", bus.in_ready); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL drain_valid got=%0h exp=0", bus.out_valid); end
    checks++; if (bus.out_sel !== 2'd2) begin failures++; $display("FAIL drain_sel_kept got=%0h exp=2", bus.out_sel); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus.in_valid = 4'b0100;
    step();
    bus.in_valid = 4'b1111;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL arst_pre_valid got=%0h exp=1", bus.out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_sel !== 2'd0 || bus.in_ready !== 4'b0000)
      begin failures++; $display("FAIL arst_immediate got v=%0h s=%0h r=%b exp v=0 s=0 r=0000", bus.out_valid, bus.out_sel, bus.in_ready); end
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 4'b0001) begin failures++; $display("FAIL arst_priority got=%b exp=0001", bus.in_ready); end
  endtask

`ifdef RR_MUX4_GRANT_COUNT_EN
  task automatic test_grant_count();
    apply_reset();
    bus.in_valid = 4'b0001;
    repeat (300) step();
    checks++; if (grant_count !== 32'h0000_00FF) begin failures++; $display("FAIL count_sat got=%h exp=000000ff", grant_count); end
    clr_counts = 1'b1;
    step();
    clr_counts = 1'b0;
    bus.in_valid = 4'b0000;
    checks++; if (grant_count !== 32'h0) begin failures++; $display("FAIL count_clr got=%h exp=00000000", grant_count); end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_sparse_wrap();
    test_drain();
    test_async_reset();
`ifdef RR_MUX4_GRANT_COUNT_EN
    test_grant_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
